// File: rtl/tpu_drain_pkg.sv
// tpu_drain_pkg: types and constants shared by the result drain stage.
package tpu_drain_pkg;
    localparam int DRAIN_FIFO_DEPTH = 2;
    localparam int DRAIN_ADDR_MAX = 32;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_e;

    typedef struct packed {
        logic [DRAIN_ADDR_MAX-1:0] addr;
        logic [7:0]                rows;
        logic [7:0]                cols;
    } drain_req_t;
endpackage

// File: rtl/result_drain_if.sv
// result_drain_if: request, output-buffer read and row-stream signals of the drain stage.
interface result_drain_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM = 32
);
    logic                                                   req_valid;
    logic                                                   req_ready;
    logic [ADDR_WIDTH-1:0]                                  req_addr;
    logic [7:0]                                             req_rows;
    logic [7:0]                                             req_cols;
    logic                                                   axim_rd_en_in;
    logic [ADDR_WIDTH-1:0]                                  axim_rd_addr_in;
    logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_ACCUM-1:0]  axim_rd_data_out;
    logic                                                   out_valid;
    logic                                                   out_ready;
    logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_ACCUM-1:0]  out_data;
    logic [7:0]                                             out_row;
    logic                                                   out_last;
    logic                                                   busy;
    logic                                                   done;

    modport slave (
        input  req_valid, req_addr, req_rows, req_cols, axim_rd_data_out, out_ready,
        output req_ready, axim_rd_en_in, axim_rd_addr_in, out_valid, out_data, out_row,
               out_last, busy, done
    );

    modport master (
        output req_valid, req_addr, req_rows, req_cols, axim_rd_data_out, out_ready,
        input  req_ready, axim_rd_en_in, axim_rd_addr_in, out_valid, out_data, out_row,
               out_last, busy, done
    );
endinterface

// File: rtl/drain_skid_fifo.sv
// drain_skid_fifo: 2-entry registered FIFO between the read return path and the row stream.
module drain_skid_fifo
    import tpu_drain_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] mem_q [DRAIN_FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [DRAIN_FIFO_DEPTH];
    logic             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             push, pop;

    assign out_valid = occ_q != 2'd0;
    assign out_data  = mem_q[rptr_q];
    assign occ       = occ_q;

    always_comb begin
        pop = out_valid & out_ready;
        in_ready = (occ_q != 2'(DRAIN_FIFO_DEPTH)) | pop;
        push = in_valid & in_ready;
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = in_data;
        wptr_d = wptr_q ^ push;
        rptr_d = rptr_q ^ pop;
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end
endmodule

// File: rtl/result_drain.sv
// result_drain: reads output-buffer rows after a task and streams them column-masked to a consumer.
module result_drain
    import tpu_drain_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM = 32
) (
    input logic           clk,
    input logic           rst,
    result_drain_if.slave bus
);
    localparam int ROW_BITS = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
    localparam int ENTRY_BITS = ROW_BITS + 9;

    typedef logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_ACCUM-1:0] row_t;

    drain_state_e          state_q, state_d;
    drain_req_t            req_q, req_d;
    logic [7:0]            issued_q, issued_d, pushed_q, pushed_d;
    logic                  inflight_q, inflight_d;
    logic                  rd_en, pop, fifo_in_ready, fifo_out_valid;
    logic [1:0]            occ;
    row_t                  masked;
    logic [ENTRY_BITS-1:0] head;

    always_comb begin
        pop = fifo_out_valid & bus.out_ready;
        // Buffered plus in-flight rows never exceed the FIFO depth.
        rd_en = (state_q == RUN) && (3'(occ) + 3'(inflight_q) - 3'(pop) <= 3'd1);
        for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++)
            masked[i] = (i < int'(req_q.cols)) ? bus.axim_rd_data_out[i] : '0;
        state_d = state_q;
        req_d = req_q;
        issued_d = issued_q + 8'(rd_en);
        pushed_d = pushed_q + 8'(inflight_q & fifo_in_ready);
        inflight_d = rd_en;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                req_d = '{addr: DRAIN_ADDR_MAX'(bus.req_addr), rows: bus.req_rows, cols: bus.req_cols};
                issued_d = 8'd0;
                pushed_d = 8'd0;
                state_d = (bus.req_rows == 8'd0) ? DONE : RUN;
            end
            RUN:   state_d = (rd_en && issued_q == req_q.rows - 8'd1) ? FLUSH : RUN;
            FLUSH: state_d = (pop && head[ENTRY_BITS-1]) ? DONE : FLUSH;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            issued_q   <= 8'd0;
            pushed_q   <= 8'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            issued_q   <= issued_d;
            pushed_q   <= pushed_d;
            inflight_q <= inflight_d;
        end
    end

    drain_skid_fifo #(.WIDTH(ENTRY_BITS)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight_q),
        .in_ready (fifo_in_ready),
        .in_data  ({pushed_q == req_q.rows - 8'd1, pushed_q, masked}),
        .out_valid(fifo_out_valid),
        .out_ready(bus.out_ready),
        .out_data (head),
        .occ      (occ)
    );

    assign bus.req_ready       = state_q == IDLE;
    assign bus.axim_rd_en_in   = rd_en;
    assign bus.axim_rd_addr_in = ADDR_WIDTH'(req_q.addr + DRAIN_ADDR_MAX'(issued_q));
    assign bus.out_valid       = fifo_out_valid;
    assign bus.out_data        = head[ROW_BITS-1:0];
    assign bus.out_row         = head[ROW_BITS +: 8];
    assign bus.out_last        = head[ENTRY_BITS-1];
    assign bus.busy            = state_q != IDLE;
    assign bus.done            = state_q == DONE;
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: scenario tasks compare the drained row stream against a row-level model of the buffer.
module tb_result_drain;
    typedef logic [15:0][31:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_drain_if #(.ADDR_WIDTH(10), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_ACCUM(32)) bus ();
    result_drain #(.ADDR_WIDTH(10), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_ACCUM(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    row_t mem [1024];
    always @(posedge clk) bus.axim_rd_data_out <= bus.axim_rd_en_in ? mem[bus.axim_rd_addr_in] : '1;

    int checks = 0;
    int errors = 0;
    row_t       q_data[$];
    logic [7:0] q_row[$];
    logic       q_last[$];
    int         q_cyc[$];
    logic [9:0] q_addr[$];
    int stab_err, rule_err, busy_err, done_cyc, done_cnt;
    logic acc_ok;

    function automatic row_t exp_row(input logic [9:0] a, input int k, input int c);
        row_t src = mem[10'(int'(a) + k)];
        row_t e;
        for (int i = 0; i < 16; i++) e[i] = (i < c) ? src[i] : 32'd0;
        return e;
    endfunction

    // Issues one request and records every strobe, beat and done pulse with its cycle offset from accept.
    task automatic drain(input logic [9:0] a, input logic [7:0] r, input logic [7:0] c, input int mode);
        bit pv, pr, plast;
        row_t pd;
        logic [7:0] prow;
        q_data.delete(); q_row.delete(); q_last.delete(); q_cyc.delete(); q_addr.delete();
        stab_err = 0; rule_err = 0; busy_err = 0; done_cyc = -1; done_cnt = 0;
        pv = 0; pr = 0; plast = 0; pd = '0; prow = '0;
        @(posedge clk); #1;
        bus.req_valid = 1; bus.req_addr = a; bus.req_rows = r; bus.req_cols = c;
        @(negedge clk);
        acc_ok = bus.req_ready;
        if (bus.busy) busy_err++;
        for (int cyc = 1; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            bus.req_valid = (cyc == 1);
            bus.req_addr = 10'($urandom); bus.req_rows = 8'($urandom); bus.req_cols = 8'($urandom);
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.axim_rd_en_in) begin
                if (q_addr.size() - q_row.size() + 1 - int'(bus.out_valid && bus.out_ready) > 2) rule_err++;
                q_addr.push_back(bus.axim_rd_addr_in);
            end
            if (pv && !pr && (!bus.out_valid || bus.out_data !== pd || bus.out_row !== prow || bus.out_last !== plast)) stab_err++;
            if (bus.out_valid && bus.out_ready) begin
                q_data.push_back(bus.out_data); q_row.push_back(bus.out_row);
                q_last.push_back(bus.out_last); q_cyc.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if ((done_cyc < 0 || cyc == done_cyc) ? !bus.busy : (bus.busy || !bus.req_ready)) busy_err++;
            if (bus.busy && bus.req_ready) busy_err++;
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; prow = bus.out_row; plast = bus.out_last;
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
        end
        bus.out_ready = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.axim_rd_en_in, bus.axim_rd_addr_in, bus.out_valid, bus.out_row, bus.out_last, bus.busy, bus.done} !== {1'b1, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b en=%b addr=%h v=%b row=%0d last=%b busy=%b done=%b", bus.req_ready, bus.axim_rd_en_in, bus.axim_rd_addr_in, bus.out_valid, bus.out_row, bus.out_last, bus.busy, bus.done);
        end
        checks++;
        if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 16; i++) mem[10'h200 + k][i] = 32'(k + 1);
        drain(10'h200, 8'd16, 8'd8, 0);
        checks++;
        if (!acc_ok || q_row.size() != 16 || q_addr.size() != 16) begin
            errors++; $display("FAIL basic_count acc=%b beats=%0d reads=%0d exp 16", acc_ok, q_row.size(), q_addr.size());
        end
        for (int j = 0; j < q_row.size(); j++) begin
            checks++;
            if (q_cyc[j] != j + 3 || q_row[j] !== 8'(j) || q_last[j] !== (j == 15) || q_data[j] !== exp_row(10'h200, j, 8)) begin
                errors++;
                $display("FAIL basic_beat%0d cyc=%0d row=%0d last=%b data=%h exp cyc=%0d data=%h", j, q_cyc[j], q_row[j], q_last[j], q_data[j], j + 3, exp_row(10'h200, j, 8));
            end
        end
        checks++;
        if (done_cyc != 19 || done_cnt != 1 || busy_err != 0 || rule_err != 0) begin
            errors++; $display("FAIL basic_done done_cyc=%0d cnt=%0d busy_err=%0d rule_err=%0d exp 19 1 0 0", done_cyc, done_cnt, busy_err, rule_err);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        drain(10'h3FE, 8'd4, 8'd16, 0);
        checks++;
        if (q_addr.size() != 4 || q_row.size() != 4) begin
            errors++; $display("FAIL wrap_count reads=%0d beats=%0d exp 4", q_addr.size(), q_row.size());
        end
        for (int j = 0; j < q_addr.size() && j < 4; j++) begin
            checks++;
            if (q_addr[j] !== exp_a[j]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", j, q_addr[j], exp_a[j]); end
        end
        for (int j = 0; j < q_row.size() && j < 4; j++) begin
            checks++;
            if (q_data[j] !== mem[exp_a[j]]) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", j, q_data[j], mem[exp_a[j]]); end
        end
    endtask

    task automatic test_backpressure();
        drain(10'h040, 8'd8, 8'd11, 1);
        checks++;
        if (q_row.size() != 8 || stab_err != 0 || rule_err != 0 || done_cnt != 1 || busy_err != 0) begin
            errors++; $display("FAIL bp_summary beats=%0d stab=%0d rule=%0d done=%0d busy_err=%0d exp 8 0 0 1 0", q_row.size(), stab_err, rule_err, done_cnt, busy_err);
        end
        for (int j = 0; j < q_row.size(); j++) begin
            checks++;
            if (q_row[j] !== 8'(j) || q_last[j] !== (j == 7) || q_data[j] !== exp_row(10'h040, j, 11)) begin
                errors++; $display("FAIL bp_beat%0d row=%0d last=%b data=%h exp data=%h", j, q_row[j], q_last[j], q_data[j], exp_row(10'h040, j, 11));
            end
        end
    endtask

    task automatic test_zero_rows();
        drain(10'h123, 8'd0, 8'd16, 0);
        checks++;
        if (!acc_ok || q_addr.size() != 0 || q_row.size() != 0 || done_cyc != 1 || done_cnt != 1 || busy_err != 0) begin
            errors++; $display("FAIL zero_rows reads=%0d beats=%0d done_cyc=%0d cnt=%0d busy_err=%0d exp 0 0 1 1 0", q_addr.size(), q_row.size(), done_cyc, done_cnt, busy_err);
        end
    endtask

    task automatic test_col_edges();
        logic [7:0] cols [2] = '{8'd0, 8'd200};
        for (int t = 0; t < 2; t++) begin
            drain(10'h300, 8'd5, cols[t], 0);
            checks++;
            if (q_row.size() != 5) begin errors++; $display("FAIL cols%0d_count got %0d exp 5", cols[t], q_row.size()); end
            for (int j = 0; j < q_row.size(); j++) begin
                checks++;
                if (q_data[j] !== ((t == 0) ? row_t'('0) : mem[10'h300 + j])) begin
                    errors++; $display("FAIL cols%0d_beat%0d got %h", cols[t], j, q_data[j]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [9:0] a = 10'($urandom);
            int r = $urandom_range(1, 20);
            int c = $urandom_range(0, 20);
            drain(a, 8'(r), 8'(c), 2);
            checks++;
            if (q_row.size() != r || q_addr.size() != r || stab_err != 0 || rule_err != 0 || busy_err != 0 || done_cnt != 1 || (r > 0 && q_row.size() == r && done_cyc != q_cyc[r - 1] + 1)) begin
                errors++; $display("FAIL rand%0d_summary beats=%0d reads=%0d exp %0d stab=%0d rule=%0d busy_err=%0d done=%0d@%0d", it, q_row.size(), q_addr.size(), r, stab_err, rule_err, busy_err, done_cnt, done_cyc);
            end
            for (int j = 0; j < q_row.size() && j < r; j++) begin
                checks++;
                if (q_row[j] !== 8'(j) || q_last[j] !== (j == r - 1) || q_data[j] !== exp_row(a, j, c) || q_addr[j] !== 10'(int'(a) + j)) begin
                    errors++; $display("FAIL rand%0d_beat%0d row=%0d last=%b addr=%h data=%h exp data=%h", it, j, q_row[j], q_last[j], q_addr[j], q_data[j], exp_row(a, j, c));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int beats = 0;
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid = 1; bus.req_addr = 10'h100; bus.req_rows = 8'd8; bus.req_cols = 8'd16; bus.out_ready = 1;
        @(posedge clk); #1 bus.req_valid = 0;
        while (beats < 3 && n < 50) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) beats++;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (beats != 3) begin errors++; $display("FAIL midrst_beats got %0d exp 3", beats); end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.axim_rd_en_in, bus.axim_rd_addr_in, bus.out_valid, bus.out_row, bus.out_last, bus.busy, bus.done} !== {1'b1, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0} || bus.out_data !== '0) begin
            errors++; $display("FAIL midrst_outputs rdy=%b en=%b v=%b row=%0d busy=%b done=%b exp 1 0 0 0 0 0", bus.req_ready, bus.axim_rd_en_in, bus.out_valid, bus.out_row, bus.busy, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got valid=%b exp 0", bus.out_valid); end
        drain(10'h150, 8'd3, 8'd5, 0);
        checks++;
        if (q_row.size() != 3) begin errors++; $display("FAIL midrst_count got %0d exp 3", q_row.size()); end
        for (int j = 0; j < q_row.size(); j++) begin
            checks++;
            if (q_row[j] !== 8'(j) || q_data[j] !== exp_row(10'h150, j, 5)) begin
                errors++; $display("FAIL midrst_beat%0d row=%0d data=%h exp row %0d", j, q_row[j], q_data[j], j);
            end
        end
    endtask

    initial begin
        bus.req_valid = 0; bus.req_addr = '0; bus.req_rows = '0; bus.req_cols = '0; bus.out_ready = 1;
        for (int k = 0; k < 1024; k++)
            for (int i = 0; i < 16; i++) mem[k][i] = $urandom;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_rows();
        test_col_edges();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
